hazard_tracker: RTL and testbench
=================================

Name: hazard_tracker

Overview:
- Decode-stage hazard controller for the 5-stage MIPS pipeline.
- Carries each instruction's destination register, write enable and Tnew value from D through E, M and W.
- Compares the D-stage instruction's Tuse against in-flight producers and raises Stall. On Stall, PC and the IF/ID register freeze and a bubble is injected into D/E.
- Drives the A3/RWE per-stage signals consumed by the forwarding unit, and runs the multiply/divide busy counter.

Parameters:
MULT_CYCLES, 5, busy duration of mult/multu in cycles (must be ≥1)
DIV_CYCLES, 10, busy duration of div/divu in cycles (must be ≥1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
IR_D  input  32  instruction in D
A3sel_D  input  2  destination select: 00 rd, 01 rt, 10 rs, 11 $31
RWE_D  input  1  D instruction writes GRF
Tnew_D  input  2  cycles after entering E until result is ready (0..2)
use_rs_D  input  1  D reads rs
use_rt_D  input  1  D reads rt
Tuse_rs_D  input  2  cycles until rs is needed (0 = in D)
Tuse_rt_D  input  2  cycles until rt is needed
md_start_D  input  1  D is mult/multu/div/divu
md_div_D  input  1  with md_start_D: 1 = div, 0 = mult
md_use_D  input  1  D is mfhi/mflo/mthi/mtlo
Stall  output  1  freeze PC and IF/ID
Flush_E  output  1  load a bubble into D/E (equals Stall)
A3_E, A3_M, A3_W  output  5 each  registered destination per stage
RWE_E, RWE_M, RWE_W  output  1 each  registered write enable per stage
Tnew_E, Tnew_M  output  2 each  registered remaining Tnew
MD_busy  output  1  multiply/divide unit busy

Behaviour:
- A3 decode in D is combinational from IR_D and A3sel_D: rd [15:11], rt [20:16], rs [25:21], or 31.
- Tracker registers update on every rising clk edge:
  - reset=1: all A3_*, RWE_*, Tnew_*, the internal md_start_E flag and the md counter go to 0. Stall therefore reads 0 in the next cycle unless D itself re-hazards.
  - Stall=1: the E slot is loaded with a bubble (A3=0, RWE=0, Tnew=0, md_start_E=0).
  - Otherwise E ← {A3_D, RWE_D, Tnew_D, md_start_D}.
  - M ← {A3_E, RWE_E, Tnew_E saturating-decremented (0 stays 0)}.
  - W ← {A3_M, RWE_M}. W has no Tnew because it is always 0.
- Register-hazard stall is combinational. For src ∈ {rs, rt}:
  - stall_src = use_src_D ∧ src≠0 ∧ [(src==A3_E ∧ RWE_E ∧ Tuse_src < Tnew_E) ∨ (src==A3_M ∧ RWE_M ∧ Tuse_src < Tnew_M)].
  - W never causes a stall; it is always forwardable.
  - A producer with A3=0 or RWE=0 never matches.
- MD counter (4-bit, width must hold max(MULT_CYCLES, DIV_CYCLES)):
  - When md_start_E=1, cnt ← (div ? DIV_CYCLES : MULT_CYCLES) − 1. md_div is latched into E alongside md_start.
  - Else if cnt≠0, cnt ← cnt−1.
  - MD_busy = md_start_E ∨ (cnt≠0). Busy therefore lasts exactly N cycles, starting with the cycle the op occupies E.
- stall_md = (md_use_D ∨ md_start_D) ∧ MD_busy.
- Stall = stall_rs ∨ stall_rt ∨ stall_md. Flush_E = Stall.
- Simultaneous events:
  - reset dominates Stall and the counter.
  - A stalled md_start_D does not enter E and does not reload the counter.
  - A new md op may issue in the same cycle cnt reaches 0, i.e. the first cycle MD_busy=0.
- Latency:
  - Stall is same-cycle, with no register.
  - Tracker outputs are valid 1 cycle after the instruction advances.

Test Plan:
- lw $1 (Tnew_D=2, RWE, A3sel=01), then add $2,$1,$3 (use_rs, Tuse_rs=1) → Stall=1 for exactly 1 cycle. On the following edge A3_M=1, Tnew_M=1, Stall=0.
- lw $1, then beq $1,$0 (Tuse_rs=0) → Stall for 2 cycles. Released when lw reaches W (A3_W=1, RWE_W=1).
- Producer targeting $0, or RWE_D=0 with matching rt → Stall never asserts. A3_E=0 or RWE_E=0 is propagated down the stages.
- mult (MULT_CYCLES=5), then mfhi in D → MD_busy high for 5 cycles and Stall=1 for those 5 cycles; mfhi enters E on the 6th. Repeat with div and DIV_CYCLES=10 → 10-cycle stall.
- Back-to-back mult, mult → second mult stalls until MD_busy falls, then issues on the first free cycle with no gap.
- Assert reset during an active lw-use stall with cnt=3 → next cycle all tracker outputs are 0, MD_busy=0 and Stall=0 (given the D instruction has no hazard).

Source files
------------

// File: rtl/hazard_tracker.sv
// hazard_tracker: decode-stage hazard controller for a 5-stage MIPS pipeline.
// Tracks destination register, write enable and Tnew of each in-flight
// instruction through E, M and W, compares the D-stage Tuse against those
// producers, and runs the multiply/divide busy counter.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   IR_D, A3sel_D              D instruction word and destination select
//   RWE_D, Tnew_D              D write enable and result latency after E entry
//   use_rs_D/use_rt_D          D reads rs / rt
//   Tuse_rs_D/Tuse_rt_D        cycles until rs / rt is needed
//   md_start_D, md_div_D       D is mult/div (md_div_D selects div)
//   md_use_D                   D is mfhi/mflo/mthi/mtlo
//   Stall, Flush_E             combinational freeze of PC/IF-ID and D/E bubble
//   A3_*, RWE_*, Tnew_*        registered per-stage producer info for forwarding
//   MD_busy                    multiply/divide unit busy
module hazard_tracker #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [1:0]  A3sel_D,
    input  logic        RWE_D,
    input  logic [1:0]  Tnew_D,
    input  logic        use_rs_D,
    input  logic        use_rt_D,
    input  logic [1:0]  Tuse_rs_D,
    input  logic [1:0]  Tuse_rt_D,
    input  logic        md_start_D,
    input  logic        md_div_D,
    input  logic        md_use_D,
    output logic        Stall,
    output logic        Flush_E,
    output logic [4:0]  A3_E,
    output logic [4:0]  A3_M,
    output logic [4:0]  A3_W,
    output logic        RWE_E,
    output logic        RWE_M,
    output logic        RWE_W,
    output logic [1:0]  Tnew_E,
    output logic [1:0]  Tnew_M,
    output logic        MD_busy
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] a3_d;
    logic             md_start_e;
    logic             md_div_e;
    logic [CNT_W-1:0] md_cnt;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic [1:0]       tnew_e_dec;
    logic             unused_ok;

    assign rs = IR_D[25:21];
    assign rt = IR_D[20:16];
    assign rd = IR_D[15:11];

    // Opcode/funct bits are decoded elsewhere; only register fields matter here.
    assign unused_ok = ^{IR_D[31:26], IR_D[10:0]};

    // Destination register select for the D instruction.
    always_comb begin
        a3_d = rd;
        case (A3sel_D)
            2'b00:   a3_d = rd;
            2'b01:   a3_d = rt;
            2'b10:   a3_d = rs;
            default: a3_d = REG_W'(31);
        endcase
    end

    // Register hazards: only E and M can be too late; W is always forwardable.
    always_comb begin
        stall_rs = use_rs_D && (rs != '0) &&
                   (((rs == A3_E) && RWE_E && (Tuse_rs_D < Tnew_E)) ||
                    ((rs == A3_M) && RWE_M && (Tuse_rs_D < Tnew_M)));
        stall_rt = use_rt_D && (rt != '0) &&
                   (((rt == A3_E) && RWE_E && (Tuse_rt_D < Tnew_E)) ||
                    ((rt == A3_M) && RWE_M && (Tuse_rt_D < Tnew_M)));
    end

    // Busy covers the cycle the md op sits in E plus the counted tail.
    assign MD_busy  = md_start_e || (md_cnt != '0);
    assign stall_md = (md_use_D || md_start_D) && MD_busy;
    assign Stall    = stall_rs || stall_rt || stall_md;
    assign Flush_E  = Stall;

    assign tnew_e_dec = (Tnew_E == 2'd0) ? 2'd0 : (Tnew_E - 2'd1);

    // Pipeline tracker registers; a stall turns the E slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            A3_E       <= '0;
            RWE_E      <= 1'b0;
            Tnew_E     <= '0;
            md_start_e <= 1'b0;
            md_div_e   <= 1'b0;
            A3_M       <= '0;
            RWE_M      <= 1'b0;
            Tnew_M     <= '0;
            A3_W       <= '0;
            RWE_W      <= 1'b0;
        end else begin
            if (Stall) begin
                A3_E       <= '0;
                RWE_E      <= 1'b0;
                Tnew_E     <= '0;
                md_start_e <= 1'b0;
                md_div_e   <= 1'b0;
            end else begin
                A3_E       <= a3_d;
                RWE_E      <= RWE_D;
                Tnew_E     <= Tnew_D;
                md_start_e <= md_start_D;
                md_div_e   <= md_div_D;
            end
            A3_M   <= A3_E;
            RWE_M  <= RWE_E;
            Tnew_M <= tnew_e_dec;
            A3_W   <= A3_M;
            RWE_W  <= RWE_M;
        end
    end

    // Multiply/divide countdown, reloaded when the op is in E.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_start_e) begin
            md_cnt <= md_div_e ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed instruction sequences with hand-computed
// per-cycle expectations queued by the driver and checked by a monitor.
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_D;
    logic [1:0]  A3sel_D;
    logic        RWE_D;
    logic [1:0]  Tnew_D;
    logic        use_rs_D, use_rt_D;
    logic [1:0]  Tuse_rs_D, Tuse_rt_D;
    logic        md_start_D, md_div_D, md_use_D;
    logic        Stall, Flush_E, MD_busy;
    logic [4:0]  A3_E, A3_M, A3_W;
    logic        RWE_E, RWE_M, RWE_W;
    logic [1:0]  Tnew_E, Tnew_M;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      name;
        bit         full;
        bit         stall;
        bit         busy;
        logic [4:0] a3e, a3m, a3w;
        bit         rwee, rwem, rwew;
        logic [1:0] tne, tnm;
    } exp_t;

    exp_t q[$];

    hazard_tracker #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .IR_D(IR_D), .A3sel_D(A3sel_D),
        .RWE_D(RWE_D), .Tnew_D(Tnew_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
        .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D), .md_start_D(md_start_D),
        .md_div_D(md_div_D), .md_use_D(md_use_D), .Stall(Stall), .Flush_E(Flush_E),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W), .RWE_E(RWE_E), .RWE_M(RWE_M),
        .RWE_W(RWE_W), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .MD_busy(MD_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, exp);
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "Stall",   32'(Stall),   32'(e.stall));
            chk(e.name, "Flush_E", 32'(Flush_E), 32'(e.stall));
            chk(e.name, "MD_busy", 32'(MD_busy), 32'(e.busy));
            if (e.full) begin
                chk(e.name, "A3_E",   32'(A3_E),   32'(e.a3e));
                chk(e.name, "RWE_E",  32'(RWE_E),  32'(e.rwee));
                chk(e.name, "Tnew_E", 32'(Tnew_E), 32'(e.tne));
                chk(e.name, "A3_M",   32'(A3_M),   32'(e.a3m));
                chk(e.name, "RWE_M",  32'(RWE_M),  32'(e.rwem));
                chk(e.name, "Tnew_M", 32'(Tnew_M), 32'(e.tnm));
                chk(e.name, "A3_W",   32'(A3_W),   32'(e.a3w));
                chk(e.name, "RWE_W",  32'(RWE_W),  32'(e.rwew));
            end
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'd0, s, t, d, 11'd0};
    endfunction

    task automatic clr();
        IR_D = '0; A3sel_D = 2'b00; RWE_D = 1'b0; Tnew_D = 2'd0;
        use_rs_D = 1'b0; use_rt_D = 1'b0; Tuse_rs_D = 2'd0; Tuse_rt_D = 2'd0;
        md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
    endtask

    task automatic lw(input logic [4:0] t);
        clr(); IR_D = mk(5'd0, t, 5'd0); A3sel_D = 2'b01; RWE_D = 1'b1; Tnew_D = 2'd2;
        use_rs_D = 1'b1; Tuse_rs_D = 2'd1;
    endtask

    task automatic add(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        clr(); IR_D = mk(s, t, d); A3sel_D = 2'b00; RWE_D = 1'b1; Tnew_D = 2'd1;
        use_rs_D = 1'b1; use_rt_D = 1'b1; Tuse_rs_D = 2'd1; Tuse_rt_D = 2'd1;
    endtask

    task automatic beq(input logic [4:0] s, input logic [4:0] t);
        clr(); IR_D = mk(s, t, 5'd0); use_rs_D = 1'b1; use_rt_D = 1'b1;
    endtask

    task automatic store_like(input logic [4:0] t);
        clr(); IR_D = mk(5'd0, t, 5'd0); A3sel_D = 2'b01; Tnew_D = 2'd2;
    endtask

    task automatic md(input bit dv);
        clr(); md_start_D = 1'b1; md_div_D = dv; use_rs_D = 1'b1; use_rt_D = 1'b1;
        Tuse_rs_D = 2'd1; Tuse_rt_D = 2'd1;
    endtask

    task automatic mfhi(input logic [4:0] d);
        clr(); IR_D = mk(5'd0, 5'd0, d); md_use_D = 1'b1; RWE_D = 1'b1; Tnew_D = 2'd1;
    endtask

    task automatic tick(input string n, input bit s, input bit b);
        exp_t e;
        e = '{name: n, full: 1'b0, stall: s, busy: b, a3e: '0, a3m: '0, a3w: '0,
              rwee: 1'b0, rwem: 1'b0, rwew: 1'b0, tne: '0, tnm: '0};
        reset = 1'b0;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic tickf(input string n, input bit s, input bit b,
                         input logic [4:0] ae, input bit re, input logic [1:0] te,
                         input logic [4:0] am, input bit rm, input logic [1:0] tm,
                         input logic [4:0] aw, input bit rw, input bit rst);
        exp_t e;
        e = '{name: n, full: 1'b1, stall: s, busy: b, a3e: ae, a3m: am, a3w: aw,
              rwee: re, rwem: rm, rwew: rw, tne: te, tnm: tm};
        reset = rst;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic flush();
        clr();
        repeat (3) tick("flush", 1'b0, 1'b0);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tickf("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // lw then dependent add: one stall cycle
        lw(5'd1);            tick("lu_lw", 0, 0);
        add(5'd2, 5'd1, 5'd3); tickf("lu_stall", 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
        tickf("lu_rel", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        clr();               tickf("lu_adv", 0, 0, 2, 1, 1, 0, 0, 0, 1, 1, 0);
        flush();

        // lw then branch using it in D: two stall cycles
        lw(5'd1);            tick("bq_lw", 0, 0);
        beq(5'd1, 5'd0);     tick("bq_s1", 1, 0);
        tickf("bq_s2", 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        tickf("bq_rel", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        flush();

        // $0 producer and non-writing producer never stall
        add(5'd0, 5'd5, 5'd6); tick("z_prod", 0, 0);
        beq(5'd0, 5'd0);     tickf("z_cons", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        store_like(5'd9);    tick("nw_prod", 0, 0);
        beq(5'd0, 5'd9);     tickf("nw_e", 0, 0, 9, 0, 2, 0, 0, 0, 0, 1, 0);
        tickf("nw_m", 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 0);
        flush();

        // mult then mfhi: 5-cycle stall
        md(1'b0);            tick("mul_iss", 0, 0);
        mfhi(5'd4);
        repeat (5) tick("mul_wait", 1, 1);
        tick("mul_free", 0, 0);
        clr();               tickf("mfhi_e", 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        flush();

        // div then mfhi: 10-cycle stall
        md(1'b1);            tick("div_iss", 0, 0);
        mfhi(5'd4);
        repeat (10) tick("div_wait", 1, 1);
        tick("div_free", 0, 0);
        flush();

        // back-to-back mult issues on first free cycle
        md(1'b0);            tick("mm_first", 0, 0);
        md(1'b0);
        repeat (5) tick("mm_wait", 1, 1);
        tick("mm_iss", 0, 0);
        clr();
        repeat (5) tick("mm_busy", 0, 1);
        tick("mm_done", 0, 0);

        // reset during a load-use stall with the md counter running
        md(1'b0);            tick("r_mul", 0, 0);
        lw(5'd1);            tick("r_lw", 0, 1);
        beq(5'd1, 5'd0);     tick("r_s1", 1, 1);
        tickf("r_rst", 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1);
        tickf("r_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr();               tick("end", 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
